alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Front-end stage feeding tt_um_alu_adder's adder/ALU core. Serially loads operand A,
//  operand B and opcode from one shared 8-bit pin bus on successive rising edges of a
//  load strobe, then issues one ALU request. Waits for completion with a timeout and
//  holds the result and carry for the output pins.
// PARAMETERS
//  WIDTH    8   operand/result width (din, alu_a, alu_b, alu_result, res_out)
//  OPW      3   opcode width; opcode = din[OPW-1:0]
//  TIMEOUT  15  max cycles in WAIT before giving up (>=1)
// PORTS
//  clk          in   1      single clock, all logic rising-edge
//  rst          in   1      synchronous reset, active-high
//  ena          in   1      0 = FSM, registers and counter hold their value
//  din          in   WIDTH  shared operand/opcode bus
//  strobe       in   1      load strobe (level); a rising edge loads din
//  alu_a        out  WIDTH  latched operand A
//  alu_b        out  WIDTH  latched operand B
//  alu_op       out  OPW    latched opcode
//  alu_valid    out  1      one-cycle issue pulse
//  alu_result   in   WIDTH  ALU result; sampled when alu_done=1
//  alu_carry    in   1      ALU carry/overflow; sampled with alu_result
//  alu_done     in   1      ALU completion; honoured only in WAIT
//  res_out      out  WIDTH  captured result
//  carry_out    out  1      captured carry
//  res_ready    out  1      result valid (high in DONE)
//  err_timeout  out  1      last request timed out (high in DONE)
//  busy         out  1      high in ISSUE or WAIT
//  state_dbg    out  3      current state encoding
// BEHAVIOUR
//  Reset: state=IDLE; alu_a/alu_b/alu_op/res_out=0; carry_out, res_ready,
//   err_timeout, alu_valid and busy=0; timeout counter=0; strobe_q=1.
//  Edge detect: edge = strobe & ~strobe_q. strobe_q <= strobe every cycle, regardless of ena.
//   strobe_q resets to 1, so strobe held high through reset release gives no load.
//   Edges occurring while ena=0 are lost.
//  States and encoding: IDLE=0, LOAD_B=1, LOAD_OP=2, ISSUE=3, WAIT=4, DONE=5.
//   All transitions below require ena=1.
//   IDLE    edge: alu_a<=din -> LOAD_B
//   LOAD_B  edge: alu_b<=din -> LOAD_OP
//   LOAD_OP edge: alu_op<=din[OPW-1:0] -> ISSUE
//   ISSUE   alu_valid=1 for exactly this cycle; counter<=0 -> WAIT (unconditional)
//   WAIT    alu_done: res_out<=alu_result, carry_out<=alu_carry, err_timeout<=0 -> DONE
//           else if counter==TIMEOUT-1: res_out<=0, carry_out<=0, err_timeout<=1 -> DONE
//           else counter<=counter+1. alu_done wins over a coincident timeout.
//   DONE    res_ready=1; outputs held. On edge: alu_a<=din, res_ready and err_timeout
//           clear -> LOAD_B. A new sequence can start without an idle gap.
//  Latency: third edge in cycle N -> alu_valid in cycle N+1.
//   alu_done in cycle M -> res_ready high from cycle M+1.
//  Strobe edges in ISSUE or WAIT are ignored and not queued.
//   alu_done outside WAIT is ignored.
//  alu_valid, busy and res_ready are pure decodes of the registered state (glitch-free).
//  No arithmetic in this block; counter width = clog2(TIMEOUT)+1 and it never wraps.
//  rst in any state, including WAIT: next cycle is IDLE with reset values.
//   A late alu_done after reset is ignored.
// TESTING
//  1. Load A=0x2D, B=0x17, op=0. Model answers 2 cycles after alu_valid with 0x44, carry 0.
//     -> alu_valid is a single pulse in cycle N+1; res_out=0x44, carry_out=0, res_ready=1.
//  2. Load A=0xFF, B=0x01, op=0; model returns 0x00 with carry 1
//     -> res_out=0x00, carry_out=1, err_timeout=0.
//  3. Complete a load; model never asserts done -> exactly 15 cycles in WAIT, then
//     DONE with err_timeout=1, res_out=0. The next edge clears the flag and loads A.
//  4. Assert rst in WAIT, then pulse alu_done
//     -> state_dbg=0, res_ready=0, all outputs 0; alu_done has no effect.
//  5. Hold strobe=1 through reset release -> no load (state_dbg=0).
//     Toggle strobe with ena=0 -> alu_a unchanged, state stays IDLE.
//  6. alu_done on the same cycle the counter reaches TIMEOUT-1
//     -> result captured, err_timeout=0. Edges during WAIT do not change alu_a.

Source files
------------

// File: rtl/alu_operand_sequencer_if.sv
// ALU-side bus of the operand sequencer: latched operands and opcode out,
// result, carry and completion back from the adder/ALU core.
interface alu_operand_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic             alu_valid;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_done;

    modport master (
        output alu_a, alu_b, alu_op, alu_valid,
        input  alu_result, alu_carry, alu_done
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_valid,
        output alu_result, alu_carry, alu_done
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Serially loads A, B and opcode from a shared pin bus on strobe rising edges,
// issues one ALU request, waits for completion with a timeout and holds the result.
module alu_operand_sequencer #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [WIDTH-1:0]        din,
    input  logic                    strobe,
    alu_operand_sequencer_if.master bus,
    output logic [WIDTH-1:0]        res_out,
    output logic                    carry_out,
    output logic                    res_ready,
    output logic                    err_timeout,
    output logic                    busy,
    output logic [2:0]              state_dbg
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD_B  = 3'd1;
    localparam logic [2:0] LOAD_OP = 3'd2;
    localparam logic [2:0] ISSUE   = 3'd3;
    localparam logic [2:0] WAIT    = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam int              CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             strobe_q, strobe_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_op_q, alu_op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             strobe_edge;

    // strobe_q idles high after reset so a strobe held through reset release is not an edge
    assign strobe_edge = strobe & ~strobe_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_d = strobe;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        res_d    = res_q;
        carry_d  = carry_q;
        err_d    = err_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (strobe_edge) begin
                        alu_a_d = din;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (strobe_edge) begin
                        alu_b_d = din;
                        state_d = LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (strobe_edge) begin
                        alu_op_d = din[OPW-1:0];
                        state_d  = ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    // a completion in the final allowed cycle still counts as success
                    if (bus.alu_done) begin
                        res_d   = bus.alu_result;
                        carry_d = bus.alu_carry;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        res_d   = '0;
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (strobe_edge) begin
                        alu_a_d = din;
                        err_d   = 1'b0;
                        state_d = LOAD_B;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b1;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_valid = (state_q == ISSUE);
    assign res_out       = res_q;
    assign carry_out     = carry_q;
    assign res_ready     = (state_q == DONE);
    assign err_timeout   = err_q;
    assign busy          = (state_q == ISSUE) || (state_q == WAIT);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed plus randomized bench for alu_operand_sequencer with an ALU responder
// and an arithmetic reference model of the expected result.
module tb_alu_operand_sequencer;

    localparam int WIDTH   = 8;
    localparam int OPW     = 3;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic [WIDTH-1:0] din;
    logic             strobe;
    logic [WIDTH-1:0] res_out;
    logic             carry_out;
    logic             res_ready;
    logic             err_timeout;
    logic             busy;
    logic [2:0]       state_dbg;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

    alu_operand_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .TIMEOUT(TIMEOUT)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .din         (din),
        .strobe      (strobe),
        .bus         (bus),
        .res_out     (res_out),
        .carry_out   (carry_out),
        .res_ready   (res_ready),
        .err_timeout (err_timeout),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // Reference ALU: {carry, result}; subtraction reports borrow in the carry bit
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] value);
        din    = value;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
    endtask

    // lat = cycles after the alu_valid cycle at which done is raised; 0 = never answer
    task automatic run_transaction(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] op_byte, input int lat,
                                   input bit noise);
        logic [2:0] op;
        logic [8:0] expect_res;
        int         n;
        op         = op_byte[2:0];
        expect_res = alu_model(a, b, op);

        applyStimulus(a);
        checkOutput("loadA_state", state_dbg, 1);
        checkOutput("loadA_value", bus.alu_a, a);
        checkOutput("loadA_ready_clr", res_ready, 0);
        checkOutput("loadA_err_clr", err_timeout, 0);
        applyStimulus(b);
        checkOutput("loadB_state", state_dbg, 2);
        checkOutput("loadB_value", bus.alu_b, b);

        din    = op_byte;
        strobe = 1'b1;
        tick();
        checkOutput("issue_valid", bus.alu_valid, 1);
        checkOutput("issue_busy", busy, 1);
        checkOutput("issue_op", bus.alu_op, op);
        strobe = 1'b0;
        tick();
        checkOutput("valid_single_pulse", bus.alu_valid, 0);
        checkOutput("wait_state", state_dbg, 4);
        checkOutput("wait_busy", busy, 1);

        if (lat > 0) begin
            for (int k = 1; k < lat; k++) begin
                if (noise) begin
                    strobe = ~strobe;
                    din    = 8'($urandom);
                end
                tick();
            end
            strobe         = 1'b0;
            bus.alu_done   = 1'b1;
            bus.alu_result = expect_res[7:0];
            bus.alu_carry  = expect_res[8];
            tick();
            bus.alu_done   = 1'b0;
            bus.alu_result = 8'($urandom);
            bus.alu_carry  = 1'b0;
            checkOutput("done_ready", res_ready, 1);
            checkOutput("done_state", state_dbg, 5);
            checkOutput("done_result", res_out, expect_res[7:0]);
            checkOutput("done_carry", carry_out, expect_res[8]);
            checkOutput("done_no_timeout", err_timeout, 0);
            checkOutput("done_busy", busy, 0);
            checkOutput("done_a_held", bus.alu_a, a);
        end else begin
            n = 0;
            while (state_dbg == 3'd4 && n < 40) begin
                n++;
                tick();
            end
            checkOutput("timeout_wait_cycles", n, TIMEOUT);
            checkOutput("timeout_ready", res_ready, 1);
            checkOutput("timeout_err", err_timeout, 1);
            checkOutput("timeout_result", res_out, 0);
            checkOutput("timeout_carry", carry_out, 0);
        end
    endtask

    initial begin
        logic [7:0] ra, rb, rop;
        rst            = 1'b1;
        ena            = 1'b1;
        din            = 8'h00;
        strobe         = 1'b1;
        bus.alu_done   = 1'b0;
        bus.alu_result = 8'h00;
        bus.alu_carry  = 1'b0;
        tick();
        tick();
        checkOutput("rst_state", state_dbg, 0);
        checkOutput("rst_a", bus.alu_a, 0);
        checkOutput("rst_b", bus.alu_b, 0);
        checkOutput("rst_op", bus.alu_op, 0);
        checkOutput("rst_valid", bus.alu_valid, 0);
        checkOutput("rst_res", res_out, 0);
        checkOutput("rst_carry", carry_out, 0);
        checkOutput("rst_ready", res_ready, 0);
        checkOutput("rst_err", err_timeout, 0);
        checkOutput("rst_busy", busy, 0);

        $display("[TB] strobe held through reset release, then edges with ena=0");
        rst = 1'b0;
        tick();
        tick();
        checkOutput("strobe_thru_reset_state", state_dbg, 0);
        ena    = 1'b0;
        strobe = 1'b0;
        tick();
        din    = 8'h99;
        strobe = 1'b1;
        tick();
        tick();
        ena = 1'b1;
        tick();
        checkOutput("ena_low_state", state_dbg, 0);
        checkOutput("ena_low_a", bus.alu_a, 0);
        strobe = 1'b0;
        tick();

        $display("[TB] directed transactions");
        run_transaction(8'h2D, 8'h17, 8'h00, 2, 1'b0);
        run_transaction(8'hFF, 8'h01, 8'h00, 2, 1'b0);
        run_transaction(8'h5A, 8'hC3, 8'h04, TIMEOUT, 1'b1);
        run_transaction(8'h11, 8'h22, 8'h00, 0, 1'b0);

        applyStimulus(8'h3C);
        checkOutput("after_timeout_state", state_dbg, 1);
        checkOutput("after_timeout_a", bus.alu_a, 8'h3C);
        checkOutput("after_timeout_err", err_timeout, 0);
        checkOutput("after_timeout_ready", res_ready, 0);

        $display("[TB] reset during WAIT with a late alu_done");
        applyStimulus(8'h55);
        applyStimulus(8'h06);
        tick();
        tick();
        checkOutput("pre_reset_wait", state_dbg, 4);
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        bus.alu_done   = 1'b1;
        bus.alu_result = 8'hAA;
        bus.alu_carry  = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        tick();
        checkOutput("wait_rst_state", state_dbg, 0);
        checkOutput("wait_rst_ready", res_ready, 0);
        checkOutput("wait_rst_res", res_out, 0);
        checkOutput("wait_rst_carry", carry_out, 0);
        checkOutput("wait_rst_a", bus.alu_a, 0);
        checkOutput("wait_rst_busy", busy, 0);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 12; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 8'($urandom);
            run_transaction(ra, rb, rop, int'($urandom_range(1, TIMEOUT)),
                            1'($urandom_range(0, 1)));
        end
        run_transaction(8'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
